dec_stage_2: RTL and testbench

SECDED decoder that receives codewords from the ECC encode path and recovers the information bits. It supports three extended-Hamming modes: (8,4), (16,11) and (32,26). The block computes the syndrome iteratively, one parity-check row per clock, then corrects a single-bit error or flags a double-bit error. It returns right-justified info bits and a status code over a valid/ready handshake.

---
 rtl/ecc_pkg.sv | 100 ++++++++++
 rtl/ecc_row_parity.sv | 12 +
 rtl/dec_stage_2.sv | 131 +++++++++++++
 tb/tb_dec_stage_2.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ecc_pkg.sv
// Shared constants, types and H-matrix helpers for the extended-Hamming SECDED decoder.
package ecc_pkg;

  localparam int unsigned MAX_CODEWORD_WIDTH = 32;
  localparam int unsigned MAX_INFO_WIDTH     = 26;
  localparam int unsigned MAX_PARITY_WIDTH   = 6;
  localparam int unsigned SYND_S_WIDTH       = MAX_PARITY_WIDTH - 1;
  localparam int unsigned ROW_IDX_WIDTH      = 3;

  localparam int unsigned N_M0 = 8;
  localparam int unsigned K_M0 = 4;
  localparam int unsigned P_M0 = 4;
  localparam int unsigned N_M1 = 16;
  localparam int unsigned K_M1 = 11;
  localparam int unsigned P_M1 = 5;
  localparam int unsigned N_M2 = 32;
  localparam int unsigned K_M2 = 26;
  localparam int unsigned P_M2 = 6;

  // Row r of each matrix lives at bits [r*N +: N]; the top row is the overall parity.
  localparam logic [N_M0*P_M0-1:0] H_M0 = 32'hffe4_d2b1;
  localparam logic [N_M1*P_M1-1:0] H_M1 = 80'hffff_fe08_f1c4_cda2_ab61;
  localparam logic [N_M2*P_M2-1:0] H_M2 =
    192'hffff_ffff_fffe_0010_ff01_fc08_f0f1_e384_cccd_9b42_aaab_56c1;

  typedef enum logic [1:0] {
    MODE_8_4     = 2'b00,
    MODE_16_11   = 2'b01,
    MODE_32_26   = 2'b10,
    MODE_ILLEGAL = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    ST_CLEAN   = 2'b00,
    ST_SINGLE  = 2'b01,
    ST_DOUBLE  = 2'b10,
    ST_ILLEGAL = 2'b11
  } status_t;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    SYND    = 2'b01,
    CORRECT = 2'b10,
    RESULT  = 2'b11
  } state_t;

  function automatic logic [ROW_IDX_WIDTH-1:0] par_width(input mode_t m);
    case (m)
      MODE_8_4:   par_width = 3'd4;
      MODE_16_11: par_width = 3'd5;
      MODE_32_26: par_width = 3'd6;
      default:    par_width = 3'd0;
    endcase
  endfunction

  function automatic logic [MAX_CODEWORD_WIDTH-1:0] cw_mask(input mode_t m);
    case (m)
      MODE_8_4:   cw_mask = 32'h0000_00ff;
      MODE_16_11: cw_mask = 32'h0000_ffff;
      MODE_32_26: cw_mask = 32'hffff_ffff;
      default:    cw_mask = 32'h0000_0000;
    endcase
  endfunction

  // Selects the syndrome bits below the overall-parity row.
  function automatic logic [SYND_S_WIDTH-1:0] synd_mask(input mode_t m);
    case (m)
      MODE_8_4:   synd_mask = 5'h07;
      MODE_16_11: synd_mask = 5'h0f;
      MODE_32_26: synd_mask = 5'h1f;
      default:    synd_mask = 5'h00;
    endcase
  endfunction

  function automatic logic [MAX_CODEWORD_WIDTH-1:0] h_row(input mode_t m,
                                                          input logic [ROW_IDX_WIDTH-1:0] r);
    logic [MAX_CODEWORD_WIDTH-1:0] row;
    row = '0;
    for (int i = 0; i < int'(P_M0); i++)
      if (m == MODE_8_4 && r == 3'(i)) row = 32'(H_M0[i*N_M0 +: N_M0]);
    for (int i = 0; i < int'(P_M1); i++)
      if (m == MODE_16_11 && r == 3'(i)) row = 32'(H_M1[i*N_M1 +: N_M1]);
    for (int i = 0; i < int'(P_M2); i++)
      if (m == MODE_32_26 && r == 3'(i)) row = H_M2[i*N_M2 +: N_M2];
    return row;
  endfunction

  // Column j of the matrix restricted to the non-overall rows.
  function automatic logic [SYND_S_WIDTH-1:0] h_col(input mode_t m, input logic [4:0] j);
    logic [MAX_CODEWORD_WIDTH-1:0] row;
    logic [SYND_S_WIDTH-1:0]       col;
    col = '0;
    for (int i = 0; i < int'(SYND_S_WIDTH); i++) begin
      row    = h_row(m, 3'(i));
      col[i] = row[j];
    end
    return col & synd_mask(m);
  endfunction

endpackage

// File: rtl/ecc_row_parity.sv
// One parity-check row evaluated against a codeword: AND then XOR-reduce.
module ecc_row_parity #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] row,
  input  logic [WIDTH-1:0] word,
  output logic             parity_c
);

  assign parity_c = ^(row & word);

endmodule

// File: rtl/dec_stage_2.sv
// Iterative SECDED decoder: one syndrome row per clock, then single-bit correct / double detect.
module dec_stage_2
  import ecc_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [MAX_CODEWORD_WIDTH-1:0] data_in,
  input  logic [1:0]                mod,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [MAX_INFO_WIDTH-1:0] data_out,
  output logic [1:0]                status
);

  state_t                          state_q;
  mode_t                           mode_q;
  logic [MAX_CODEWORD_WIDTH-1:0]   word_q;
  logic [MAX_PARITY_WIDTH-1:0]     synd_q;
  logic [ROW_IDX_WIDTH-1:0]        row_q;

  mode_t                           mod_c;
  logic [ROW_IDX_WIDTH-1:0]        p_c;
  logic [ROW_IDX_WIDTH-1:0]        last_row_c;
  logic [MAX_CODEWORD_WIDTH-1:0]   row_c;
  logic                            row_par_c;
  logic [MAX_CODEWORD_WIDTH-1:0]   mask_c;
  logic [SYND_S_WIDTH-1:0]         synd_s_c;
  logic                            op_c;
  logic [MAX_CODEWORD_WIDTH-1:0]   flip_c;
  logic [MAX_CODEWORD_WIDTH-1:0]   fixed_c;
  logic [MAX_INFO_WIDTH-1:0]       info_c;
  status_t                         status_c;

  assign mod_c      = mode_t'(mod);
  assign p_c        = par_width(mode_q);
  assign last_row_c = p_c - 3'd1;
  assign row_c      = h_row(mode_q, row_q);
  assign mask_c     = cw_mask(mode_q);
  assign synd_s_c   = synd_q[SYND_S_WIDTH-1:0] & synd_mask(mode_q);

  ecc_row_parity #(
    .WIDTH (MAX_CODEWORD_WIDTH)
  ) u_row_parity (
    .row      (row_c),
    .word     (word_q),
    .parity_c (row_par_c)
  );

  // Overall-parity bit sits in the top syndrome row of the active mode.
  always_comb begin
    op_c = 1'b0;
    case (mode_q)
      MODE_8_4:   op_c = synd_q[3];
      MODE_16_11: op_c = synd_q[4];
      MODE_32_26: op_c = synd_q[5];
      default:    op_c = 1'b0;
    endcase
  end

  // Columns are unique, so at most one position matches; s=0 matches the overall-parity bit.
  for (genvar j = 0; j < int'(MAX_CODEWORD_WIDTH); j++) begin : g_col
    assign flip_c[j] = mask_c[j] && (h_col(mode_q, 5'(j)) == synd_s_c);
  end

  always_comb begin
    fixed_c  = op_c ? (word_q ^ flip_c) : word_q;
    info_c   = 26'(fixed_c >> p_c);
    status_c = ST_CLEAN;
    if (op_c)                 status_c = ST_SINGLE;
    else if (synd_s_c != '0)  status_c = ST_DOUBLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      mode_q    <= MODE_8_4;
      word_q    <= '0;
      synd_q    <= '0;
      row_q     <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      data_out  <= '0;
      status    <= ST_CLEAN;
    end else begin
      case (state_q)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            in_ready <= 1'b0;
            mode_q   <= mod_c;
            word_q   <= data_in & cw_mask(mod_c);
            synd_q   <= '0;
            row_q    <= '0;
            if (mod_c == MODE_ILLEGAL) begin
              data_out <= '0;
              status   <= ST_ILLEGAL;
              state_q  <= RESULT;
            end else begin
              state_q  <= SYND;
            end
          end
        end
        SYND: begin
          synd_q[row_q] <= row_par_c;
          if (row_q == last_row_c) state_q <= CORRECT;
          else                     row_q   <= row_q + 3'd1;
        end
        CORRECT: begin
          data_out  <= info_c;
          status    <= status_c;
          out_valid <= 1'b1;
          state_q   <= RESULT;
        end
        RESULT: begin
          // Illegal-mode words arrive here with out_valid still low.
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dec_stage_2.sv
// Scoreboard bench for dec_stage_2: directed codewords, latency, protocol and reset checks.
module tb_dec_stage_2;

  localparam logic [31:0]  TB_H0 = 32'hffe4_d2b1;
  localparam logic [79:0]  TB_H1 = 80'hffff_fe08_f1c4_cda2_ab61;
  localparam logic [191:0] TB_H2 =
    192'hffff_ffff_fffe_0010_ff01_fc08_f0f1_e384_cccd_9b42_aaab_56c1;

  typedef struct {
    logic [25:0] data;
    logic [1:0]  status;
    int          lat;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] data_in;
  logic [1:0]  mod;
  logic        out_valid;
  logic        out_ready;
  logic [25:0] data_out;
  logic [1:0]  status;

  exp_t sb_q[$];
  int   n_vec  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  int   accept_cyc = 0;

  dec_stage_2 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .mod       (mod),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .status    (status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int tb_p(input int m);
    return (m == 0) ? 4 : (m == 1) ? 5 : 6;
  endfunction

  function automatic int tb_n(input int m);
    return (m == 0) ? 8 : (m == 1) ? 16 : 32;
  endfunction

  function automatic logic [31:0] tb_row(input int m, input int r);
    logic [191:0] h;
    int n;
    h = (m == 0) ? 192'(TB_H0) : (m == 1) ? 192'(TB_H1) : TB_H2;
    n = tb_n(m);
    h = h >> (r * n);
    return (n == 32) ? h[31:0] : (h[31:0] & ((32'd1 << n) - 32'd1));
  endfunction

  // Systematic encoder: parity columns are unit vectors, so each check bit is one row's XOR.
  function automatic logic [31:0] encode(input int m, input logic [31:0] info);
    int p;
    logic [31:0] w;
    p = tb_p(m);
    w = info << p;
    for (int r = 0; r < p - 1; r++) w[r] = ^(tb_row(m, r) & w);
    w[p-1] = ^w;
    return w;
  endfunction

  function automatic logic [25:0] raw_info(input int m, input logic [31:0] w);
    logic [31:0] v;
    v = (w >> tb_p(m)) & ((32'd1 << (tb_n(m) - tb_p(m))) - 32'd1);
    return v[25:0];
  endfunction

  task automatic issue(input logic [1:0] m, input logic [31:0] d, input logic [25:0] ed,
                       input logic [1:0] es, input int lat, input bit push);
    int guard;
    exp_t e;
    e.data = ed; e.status = es; e.lat = lat;
    if (push) sb_q.push_back(e);
    data_in  = d;
    mod      = m;
    in_valid = 1'b1;
    guard    = 0;
    while (!in_ready && guard < 30) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!in_ready) check("in_ready_wait", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    accept_cyc = cyc;
    in_valid = 1'b0;
    data_in  = ~d;
    mod      = 2'b11;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sb_q.size() != 0 && guard < 40) begin
      @(posedge clk); #1;
      guard++;
    end
    if (sb_q.size() != 0) begin
      check("drain_timeout", 32'(sb_q.size()), 32'd0);
      sb_q.delete();
    end
  endtask

  task automatic run(input logic [1:0] m, input logic [31:0] d, input logic [25:0] ed,
                     input logic [1:0] es, input int lat);
    issue(m, d, ed, es, lat, 1'b1);
    drain();
  endtask

  // Monitor: latency on first out_valid, payload on handshake.
  initial begin : monitor
    bit   seen;
    exp_t e;
    seen = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        seen = 1'b0;
      end else begin
        if (out_valid && !seen) begin
          seen = 1'b1;
          if (sb_q.size() == 0) check("unexpected_output", 32'(sb_q.size()), 32'd1);
          else if (sb_q[0].lat != 0) check("latency", 32'(cyc - accept_cyc + 1), 32'(sb_q[0].lat));
        end
        if (out_valid && out_ready) begin
          seen = 1'b0;
          if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check("data_out", 32'(data_out), 32'(e.data));
            check("status", 32'(status), 32'(e.status));
          end
        end
      end
    end
  end

  initial begin : stim
    logic [31:0] cw;
    logic [31:0] bad;
    logic [31:0] infos1 [3];
    logic [31:0] infos2 [3];
    int guard;
    infos1 = '{32'h0000_05a3, 32'h0000_0000, 32'h0000_07ff};
    infos2 = '{32'h02b3_c5d1, 32'h0000_0000, 32'h03ff_ffff};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; data_in = '0; mod = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_status", 32'(status), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // (8,4) hand-computed vectors
    run(2'b00, 32'h0000_00aa, 26'ha, 2'b00, 6);
    run(2'b00, 32'h0000_008a, 26'ha, 2'b01, 6);
    run(2'b00, 32'h0000_00a2, 26'ha, 2'b01, 6);
    run(2'b00, 32'h0000_008b, 26'h8, 2'b10, 6);
    run(2'b00, 32'hffff_ffaa, 26'ha, 2'b00, 6);
    run(2'b00, 32'h0000_0000, 26'h0, 2'b00, 6);

    // Illegal mode
    run(2'b11, 32'hdead_beef, 26'h0, 2'b11, 2);
    run(2'b11, 32'h0000_00aa, 26'h0, 2'b11, 2);

    // (16,11): clean words, then every single-bit flip, then a double
    for (int i = 0; i < 3; i++) run(2'b01, encode(1, infos1[i]), infos1[i][25:0], 2'b00, 7);
    cw = encode(1, infos1[0]);
    for (int j = 0; j < 16; j++) run(2'b01, cw ^ (32'd1 << j), infos1[0][25:0], 2'b01, 7);
    bad = cw ^ 32'h0000_1001;
    run(2'b01, bad, raw_info(1, bad), 2'b10, 7);

    // (32,26)
    for (int i = 0; i < 3; i++) run(2'b10, encode(2, infos2[i]), infos2[i][25:0], 2'b00, 8);
    cw = encode(2, infos2[0]);
    for (int j = 0; j < 32; j++) run(2'b10, cw ^ (32'd1 << j), infos2[0][25:0], 2'b01, 8);
    bad = cw ^ 32'h8000_0040;
    run(2'b10, bad, raw_info(2, bad), 2'b10, 8);

    // Consumer stall: outputs hold, no new acceptance
    out_ready = 1'b0;
    issue(2'b00, 32'h0000_008a, 26'ha, 2'b01, 6, 1'b1);
    guard = 0;
    while (!out_valid && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    check("stall_out_valid", 32'(out_valid), 32'd1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("stall_hold_valid", 32'(out_valid), 32'd1);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_data", 32'(data_out), 32'ha);
      check("stall_status", 32'(status), 32'd1);
    end
    out_ready = 1'b1;
    drain();

    // Reset during SYND abandons the word
    issue(2'b10, encode(2, infos2[0]), 26'h0, 2'b00, 0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("midrst_release_in_ready", 32'(in_ready), 32'd1);
    repeat (12) @(posedge clk);
    #1;
    check("midrst_no_output", 32'(out_valid), 32'd0);
    run(2'b01, encode(1, infos1[0]) ^ 32'h0000_0200, infos1[0][25:0], 2'b01, 7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
